ring_osc_freq_meter: RTL and testbench

- Measures the ring oscillator frequency in the system clock domain. It drives the oscillator enable, synchronises the divided oscillator output, and counts its rising edges over a programmable gate window.
- Sits directly downstream of the ring oscillator: osc_ena feeds the oscillator's ena input and osc_in takes its divided clock output.
- The result is an edge count per gate window, read by the host logic or scan chain.

---
 rtl/ring_osc_freq_meter.sv | 136 +++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator frequency meter: enables the oscillator, synchronises its
// divided output into clk and counts rising edges over a gate window.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   start        measurement request, accepted only while idle
//   gate_cycles  window length in clk cycles, latched on acceptance
//   osc_in       divided oscillator clock, asynchronous to clk
//   osc_ena      oscillator enable (high during warm-up and measurement)
//   busy         measurement in progress
//   done         one-cycle pulse when count is final
//   count        saturating rising-edge count of the last/current window
//   overflow     sticky flag, counter saturated during the window
module ring_osc_freq_meter #(
    parameter int GATE_BITS     = 16,
    parameter int COUNT_WIDTH   = 16,
    parameter int WARMUP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [GATE_BITS-1:0]   gate_cycles,
    input  logic                   osc_in,
    output logic                   osc_ena,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    localparam int WB = $clog2(WARMUP_CYCLES);
    localparam int TW = (GATE_BITS > WB) ? GATE_BITS : WB;

    // One timer serves both phases: loaded with (length - 1), the phase
    // ends on the cycle the timer reads zero.
    localparam logic [TW-1:0] WARM_LOAD = TW'(WARMUP_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WARMUP  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [GATE_BITS-1:0]   gate_q, gate_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   rise;

    // Synchroniser and edge flop run in every state, so the warm-up
    // phase flushes any stale level before counting starts.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        tmr_d   = tmr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    gate_d  = gate_cycles;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = WARM_LOAD;
                    state_d = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (tmr_q == '0) begin
                    if (gate_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        tmr_d   = TW'(gate_q) - TW'(1);
                        state_d = S_MEASURE;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_MEASURE: begin
                if (rise) begin
                    // Saturate at all-ones and flag the lost edges.
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            gate_q  <= '0;
            tmr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= osc_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            gate_q  <= gate_d;
            tmr_q   <= tmr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_WARMUP) || (state_q == S_MEASURE);
    assign osc_ena  = busy;
    assign done     = (state_q == S_DONE);
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: instance 0 is the default build, instance 1
// uses a 4-bit counter to reach saturation quickly.
module tb_ring_osc_freq_meter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] start;
    logic [1:0] osc;
    logic [15:0] gate [2];
    wire  [1:0] ena;
    wire  [1:0] bsy;
    wire  [1:0] dn;
    wire  [1:0] ovf;
    wire  [15:0] cnt0;
    wire  [3:0] cnt1;

    ring_osc_freq_meter #(.GATE_BITS(16), .COUNT_WIDTH(16),
                          .WARMUP_CYCLES(W)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]),
        .gate_cycles(gate[0]), .osc_in(osc[0]), .osc_ena(ena[0]),
        .busy(bsy[0]), .done(dn[0]), .count(cnt0), .overflow(ovf[0])
    );

    ring_osc_freq_meter #(.GATE_BITS(16), .COUNT_WIDTH(4),
                          .WARMUP_CYCLES(W)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]),
        .gate_cycles(gate[1]), .osc_in(osc[1]), .osc_ena(ena[1]),
        .busy(bsy[1]), .done(dn[1]), .count(cnt1), .overflow(ovf[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model: cycles since acceptance, window length, and the
    // number of osc rising edges seen at clk samples during the window.
    int rt  [2];
    int gg  [2];
    int m   [2];
    int tol [2];
    bit po  [2];
    int per [2];
    int ph  [2];
    bit lvl [2];

    function automatic int cntv(int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    function automatic int maxc(int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    task automatic chk_eq(string nm, int i, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0d want %0d",
                     nm, i, cyc, act, exp);
        end
    endtask

    task automatic chk_rng(string nm, int i, int act, int lo, int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0d want %0d..%0d",
                     nm, i, cyc, act, lo, hi);
        end
    endtask

    task automatic model_step(int i);
        if (rst[i]) begin
            rt[i] = 0;
            m[i] = 0;
            tol[i] = 0;
        end else if (rt[i] == 0) begin
            if (start[i]) begin
                rt[i] = 1;
                gg[i] = int'(gate[i]);
                m[i] = 0;
                tol[i] = 0;
            end
        end else if (rt[i] == W + gg[i] + 1) begin
            rt[i] = 0;
        end else begin
            if (rt[i] > W) begin
                if (osc[i] && !po[i]) m[i]++;
                tol[i] = 1;
            end
            rt[i]++;
        end
        po[i] = osc[i];
    endtask

    task automatic osc_gen(int i);
        ph[i]++;
        if (per[i] == 0) osc[i] = lvl[i];
        else osc[i] = ((ph[i] % per[i]) < per[i] / 2);
    endtask

    task automatic check(int i);
        bit eb, ed;
        int lo, hi, mx;
        eb = (rt[i] >= 1) && (rt[i] <= W + gg[i]);
        ed = (rt[i] == W + gg[i] + 1);
        chk_eq("busy", i, int'(bsy[i]), int'(eb));
        chk_eq("osc_ena", i, int'(ena[i]), int'(eb));
        chk_eq("done", i, int'(dn[i]), int'(ed));
        if (!(rt[i] > W && rt[i] <= W + gg[i])) begin
            mx = maxc(i);
            lo = m[i] - tol[i];
            if (lo < 0) lo = 0;
            hi = m[i] + tol[i];
            if (lo > mx) lo = mx;
            if (hi > mx) hi = mx;
            chk_rng("count", i, cntv(i), lo, hi);
            if (m[i] - tol[i] > mx) chk_eq("overflow", i, int'(ovf[i]), 1);
            else if (m[i] + tol[i] <= mx)
                chk_eq("overflow", i, int'(ovf[i]), 0);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int i, int lim, output int dc);
        bit got;
        got = 0;
        dc = -1;
        for (int k = 0; k < lim && !got; k++) begin
            @(negedge clk);
            if (dn[i]) begin
                got = 1;
                dc = cyc;
            end
        end
        if (!got) chk_eq("done_timeout", i, 0, 1);
    endtask

    // Pulses start for one cycle; s0 is the cycle in which start is high.
    task automatic run1(int i, int g, output int s0, output int dc);
        tick(1);
        gate[i] = 16'(g);
        start[i] = 1'b1;
        s0 = cyc;
        tick(1);
        start[i] = 1'b0;
        wait_done(i, g + W + 20, dc);
    endtask

    int s0, dc, nd, prevdc;

    initial begin
        rst = 2'b11;
        start = 2'b00;
        osc = 2'b00;
        for (int i = 0; i < 2; i++) begin
            gate[i] = '0;
            rt[i] = 0; gg[i] = 0; m[i] = 0; tol[i] = 0;
            po[i] = 0; per[i] = 0; ph[i] = 0; lvl[i] = 0;
        end
        fork
            forever begin
                @(posedge clk);
                cyc++;
                for (int i = 0; i < 2; i++) model_step(i);
                #3;
                for (int i = 0; i < 2; i++) osc_gen(i);
            end
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) check(i);
            end
        join_none

        tick(3);
        rst = 2'b00;
        @(negedge clk);
        chk_eq("rst_busy", 0, int'(bsy[0]), 0);
        chk_eq("rst_count", 0, int'(cnt0), 0);
        chk_eq("rst_ovf", 1, int'(ovf[1]), 0);

        // 1: period 10, gate 100
        per[0] = 10;
        tick(5);
        run1(0, 100, s0, dc);
        chk_eq("t1_latency", 0, dc - s0, 109);
        chk_rng("t1_count", 0, int'(cnt0), 9, 11);
        chk_eq("t1_ovf", 0, int'(ovf[0]), 0);

        // 2: 4-bit counter saturates, then a short window clears it
        per[1] = 4;
        tick(5);
        run1(1, 100, s0, dc);
        chk_eq("t2_count_sat", 1, int'(cnt1), 15);
        chk_eq("t2_ovf_set", 1, int'(ovf[1]), 1);
        tick(3);
        run1(1, 8, s0, dc);
        chk_rng("t2_count_short", 1, int'(cnt1), 1, 3);
        chk_eq("t2_ovf_clr", 1, int'(ovf[1]), 0);

        // 3: zero-length gate
        tick(3);
        run1(0, 0, s0, dc);
        chk_eq("t3_latency", 0, dc - s0, 9);
        chk_eq("t3_count", 0, int'(cnt0), 0);

        // 4: static high osc, stray starts ignored
        per[0] = 0;
        lvl[0] = 1'b1;
        tick(6);
        tick(1);
        gate[0] = 16'd50;
        start[0] = 1'b1;
        s0 = cyc;
        tick(1);
        start[0] = 1'b0;
        tick(3);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(20);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        wait_done(0, 80, dc);
        chk_eq("t4_latency", 0, dc - s0, 59);
        chk_eq("t4_count", 0, int'(cnt0), 0);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk_eq("t4_extra_done", 0, nd, 0);

        // 5: reset mid-measurement aborts
        per[0] = 10;
        lvl[0] = 1'b0;
        tick(5);
        gate[0] = 16'd100;
        start[0] = 1'b1;
        s0 = cyc;
        tick(1);
        start[0] = 1'b0;
        tick(38);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        @(negedge clk);
        chk_eq("t5_busy", 0, int'(bsy[0]), 0);
        chk_eq("t5_ena", 0, int'(ena[0]), 0);
        chk_eq("t5_done", 0, int'(dn[0]), 0);
        chk_eq("t5_count", 0, int'(cnt0), 0);
        chk_eq("t5_ovf", 0, int'(ovf[0]), 0);
        nd = 0;
        repeat (120) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk_eq("t5_no_done", 0, nd, 0);
        run1(0, 100, s0, dc);
        chk_rng("t5_rerun_count", 0, int'(cnt0), 9, 11);

        // 6: start held high gives back-to-back runs
        tick(3);
        gate[0] = 16'd20;
        start[0] = 1'b1;
        s0 = cyc;
        nd = 0;
        prevdc = -1;
        repeat (300) begin
            @(negedge clk);
            if (dn[0]) begin
                if (prevdc < 0) chk_eq("t6_first", 0, cyc - s0, 29);
                else chk_eq("t6_spacing", 0, cyc - prevdc, 30);
                chk_rng("t6_count", 0, int'(cnt0), 1, 3);
                prevdc = cyc;
                nd++;
            end
        end
        chk_eq("t6_ndone", 0, nd, 10);
        tick(1);
        start[0] = 1'b0;
        tick(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
